// File: rtl/risc_pkg.sv
// Shared RISC datapath types: ALU opcodes, the ID/EX stage state encoding
// and the operand entry held by the ID/EX skid buffer.
package risc_pkg;

  localparam int RISC_DATA_W = 32;
  localparam int RISC_REG_AW = 5;
  localparam int RISC_OP_W   = 4;

  typedef logic [RISC_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD  = 4'd0;
  localparam alu_op_t ALU_OP_SUB  = 4'd1;
  localparam alu_op_t ALU_OP_AND  = 4'd2;
  localparam alu_op_t ALU_OP_OR   = 4'd3;
  localparam alu_op_t ALU_OP_XOR  = 4'd4;
  localparam alu_op_t ALU_OP_SLT  = 4'd5;
  localparam alu_op_t ALU_OP_SHLL = 4'd6;
  localparam alu_op_t ALU_OP_SHRL = 4'd7;
  localparam alu_op_t ALU_OP_SHRA = 4'd8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [RISC_DATA_W-1:0] a_val;
    logic [RISC_DATA_W-1:0] b_val;
    logic [RISC_REG_AW-1:0] rs_addr;
    logic [RISC_REG_AW-1:0] rt_addr;
    logic                   use_imm;
    alu_op_t                alu_op;
    logic [RISC_REG_AW-1:0] rd_addr;
  } operand_entry_t;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == ALU_OP_SHLL) || (op == ALU_OP_SHRL) || (op == ALU_OP_SHRA);
  endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// Writeback forwarding select: replaces a register value with the writeback
// data when the writeback targets the same nonzero register.
module ex_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              fwd_we,
  input  logic [REG_AW-1:0] fwd_addr,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] result
);

  // r0 is hardwired zero and must never pick up a forwarded value
  assign result = (fwd_we && (fwd_addr == addr) && (addr != {REG_AW{1'b0}})) ? fwd_data : data;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: forwarding capture into a 2-entry skid buffer.
// Optional macro SHAMT_MASK_EN limits shift amounts on op_b to 0-31.
module ex_operand_stage
  import risc_pkg::*;
#(
  parameter int DATA_W = RISC_DATA_W,
  parameter int REG_AW = RISC_REG_AW,
  parameter int OP_W   = RISC_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              fwd_we,
  input  logic [REG_AW-1:0] fwd_addr,
  input  logic [DATA_W-1:0] fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [OP_W-1:0]   out_alu_op,
  output logic [REG_AW-1:0] out_rd_addr
);

`ifdef SHAMT_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  // Forwarded values also pass through here so a shift never sees bits above 4
  function automatic logic [DATA_W-1:0] shape_b(input alu_op_t op, input logic [DATA_W-1:0] b);
    if (MASK_EN && is_shift_op(op)) begin
      return {{(DATA_W-5){1'b0}}, b[4:0]};
    end else begin
      return b;
    end
  endfunction

  stage_state_t   state, state_nxt;
  operand_entry_t main_q, skid_q, main_nxt, skid_nxt, main_h, skid_h, cap_e;
  logic [DATA_W-1:0] cap_a, cap_rt, main_a, main_b, skid_a, skid_b;
  logic accept, pop;

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cap_a (
    .addr(rs_addr), .data(rs_data), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .result(cap_a));
  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_cap_b (
    .addr(rt_addr), .data(rt_data), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .result(cap_rt));
  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_main_a (
    .addr(main_q.rs_addr), .data(main_q.a_val), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .result(main_a));
  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_main_b (
    .addr(main_q.rt_addr), .data(main_q.b_val), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .result(main_b));
  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_skid_a (
    .addr(skid_q.rs_addr), .data(skid_q.a_val), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .result(skid_a));
  ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_skid_b (
    .addr(skid_q.rt_addr), .data(skid_q.b_val), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .result(skid_b));

  // Incoming entry and both held entries after this cycle's writeback forwarding
  always_comb begin
    cap_e         = '0;
    cap_e.a_val   = cap_a;
    cap_e.b_val   = shape_b(alu_op, use_imm ? imm : cap_rt);
    cap_e.rs_addr = rs_addr;
    cap_e.rt_addr = rt_addr;
    cap_e.use_imm = use_imm;
    cap_e.alu_op  = alu_op;
    cap_e.rd_addr = rd_addr;

    main_h        = main_q;
    main_h.a_val  = main_a;
    main_h.b_val  = main_q.use_imm ? main_q.b_val : shape_b(main_q.alu_op, main_b);
    skid_h        = skid_q;
    skid_h.a_val  = skid_a;
    skid_h.b_val  = skid_q.use_imm ? skid_q.b_val : shape_b(skid_q.alu_op, skid_b);
  end

  // Occupancy transitions; flush drops everything including a same-cycle accept
  always_comb begin
    state_nxt = state;
    main_nxt  = main_h;
    skid_nxt  = skid_h;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_nxt  = cap_e;
            state_nxt = ST_ONE;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_nxt = cap_e;
          end else if (accept) begin
            skid_nxt  = cap_e;
            state_nxt = ST_TWO;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end else begin
            state_nxt = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_nxt  = skid_h;
            state_nxt = ST_ONE;
          end else begin
            state_nxt = ST_TWO;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State and entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  assign op_a        = main_q.a_val;
  assign op_b        = main_q.b_val;
  assign out_alu_op  = main_q.alu_op;
  assign out_rd_addr = main_q.rd_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_ex_operand_stage;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, use_imm, fwd_we, out_valid, out_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr, fwd_addr, out_rd_addr;
  logic [31:0] rs_data, rt_data, imm, fwd_data, op_a, op_b;
  logic [3:0]  alu_op, out_alu_op;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        use_imm;
    logic [3:0]  op;
  } ref_t;
  ref_t mq[$];

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .use_imm(use_imm), .alu_op(alu_op), .rd_addr(rd_addr),
    .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .out_alu_op(out_alu_op), .out_rd_addr(out_rd_addr));

  function automatic logic [31:0] fwd_sel(input logic [4:0] addr, input logic [31:0] data);
    if (fwd_we && addr != 5'd0 && addr == fwd_addr) return fwd_data;
    return data;
  endfunction

  function automatic logic [31:0] shamt_fix(input logic [3:0] op, input logic [31:0] b);
`ifdef SHAMT_MASK_EN
    if (op == 4'd6 || op == 4'd7 || op == 4'd8) return b % 32;
`endif
    return b;
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_imm = 1'b0; fwd_we = 1'b0;
    rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0; fwd_addr = 5'd0;
    rs_data = 32'd0; rt_data = 32'd0; imm = 32'd0; fwd_data = 32'd0; alu_op = 4'd0;
  endtask

  // One clock with the current inputs; the reference queue follows along
  task automatic tick();
    bit   acc, pp;
    ref_t e;
    acc = in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_ready;
    e.a = fwd_sel(rs_addr, rs_data);
    e.b = shamt_fix(alu_op, use_imm ? imm : fwd_sel(rt_addr, rt_data));
    e.rs = rs_addr; e.rt = rt_addr; e.rd = rd_addr; e.use_imm = use_imm; e.op = alu_op;
    foreach (mq[i]) begin
      mq[i].a = fwd_sel(mq[i].rs, mq[i].a);
      if (!mq[i].use_imm) mq[i].b = shamt_fix(mq[i].op, fwd_sel(mq[i].rt, mq[i].b));
    end
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if ({op_a, op_b, out_alu_op, out_rd_addr} !== 73'd0) begin
      failures++; $display("FAIL reset_outputs got a=%h b=%h op=%h rd=%h exp all 0", op_a, op_b, out_alu_op, out_rd_addr);
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    in_valid = 1'b1; rs_addr = 5'd1; rs_data = 32'h1; rt_addr = 5'd2; rt_data = 32'd4;
    alu_op = ALU_OP_SHLL; rd_addr = 5'd9;
    tick();
    checks++; if (out_valid !== 1'b1 || op_a !== 32'h1 || op_b !== 32'h4 || out_rd_addr !== 5'd9) begin
      failures++; $display("FAIL basic got v=%0b a=%h b=%h rd=%0d exp v=1 a=1 b=4 rd=9", out_valid, op_a, op_b, out_rd_addr);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pop got v=%0b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a [6] = '{32'h100, 32'h100, 32'h100, 32'h101, 32'h102, 32'h0};
    logic        exp_r [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idle_inputs();
    rs_addr = 5'd1; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rs_data   = 32'h100 + ((c < 2) ? c : 2);
      out_ready = (c >= 3);
      in_valid  = (c < 5);
      tick();
      checks++; if (in_ready !== exp_r[c]) begin
        failures++; $display("FAIL b2b_in_ready cyc%0d got %0b exp %0b", c, in_ready, exp_r[c]);
      end
      checks++; if (c < 5 && (out_valid !== 1'b1 || op_a !== exp_a[c])) begin
        failures++; $display("FAIL b2b_order cyc%0d got v=%0b a=%h exp v=1 a=%h", c, out_valid, op_a, exp_a[c]);
      end else if (c == 5 && out_valid !== 1'b0) begin
        failures++; $display("FAIL b2b_drain got v=%0b exp 0", out_valid);
      end
    end
  endtask

  task automatic test_fwd_capture();
    idle_inputs();
    in_valid = 1'b1; out_ready = 1'b1; rs_addr = 5'd5; rs_data = 32'h1234;
    fwd_we = 1'b1; fwd_addr = 5'd5; fwd_data = 32'hDEADBEEF;
    tick();
    checks++; if (op_a !== 32'hDEADBEEF) begin failures++; $display("FAIL fwd_capture got %h exp deadbeef", op_a); end
    rs_addr = 5'd0; fwd_addr = 5'd0; rs_data = 32'h55;
    tick();
    checks++; if (op_a !== 32'h55) begin failures++; $display("FAIL fwd_r0 got %h exp 00000055", op_a); end
    in_valid = 1'b0; fwd_we = 1'b0;
    tick();
  endtask

  task automatic test_fwd_hold();
    idle_inputs();
    in_valid = 1'b1; rt_addr = 5'd3; rt_data = 32'h9; alu_op = ALU_OP_ADD;
    tick();
    in_valid = 1'b0; fwd_we = 1'b1; fwd_addr = 5'd3; fwd_data = 32'h2;
    tick();
    checks++; if (op_b !== 32'h2) begin failures++; $display("FAIL fwd_hold got %h exp 00000002", op_b); end
    fwd_we = 1'b0; out_ready = 1'b1; in_valid = 1'b1; use_imm = 1'b1; imm = 32'h77;
    tick();
    out_ready = 1'b0; in_valid = 1'b0; fwd_we = 1'b1;
    tick();
    checks++; if (op_b !== 32'h77) begin failures++; $display("FAIL fwd_hold_imm got %h exp 00000077", op_b); end
    idle_inputs(); out_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; rs_data = 32'hA;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_setup got in_ready=%0b exp 0", in_ready); end
    flush = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_emit cyc%0d got v=%0b exp 0", c, out_valid); end
    end
  endtask

  task automatic test_shamt();
    logic [31:0] exp_shl;
`ifdef SHAMT_MASK_EN
    exp_shl = 32'h05;
`else
    exp_shl = 32'h25;
`endif
    idle_inputs();
    in_valid = 1'b1; out_ready = 1'b1; rt_addr = 5'd4; rt_data = 32'h25; alu_op = ALU_OP_SHLL;
    tick();
    checks++; if (op_b !== exp_shl) begin failures++; $display("FAIL shamt_shll got %h exp %h", op_b, exp_shl); end
    alu_op = ALU_OP_ADD;
    tick();
    checks++; if (op_b !== 32'h25) begin failures++; $display("FAIL shamt_add got %h exp 00000025", op_b); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rs_addr   = 5'($urandom_range(0, 3));
      rt_addr   = 5'($urandom_range(0, 3));
      rd_addr   = 5'($urandom_range(0, 31));
      rs_data   = $urandom; rt_data = $urandom; imm = $urandom;
      if ($urandom_range(0, 1) == 0) rt_data = rt_data % 64;
      use_imm   = ($urandom_range(0, 3) == 0);
      alu_op    = 4'($urandom_range(0, 15));
      fwd_we    = ($urandom_range(0, 1) == 1);
      fwd_addr  = 5'($urandom_range(0, 3));
      fwd_data  = $urandom;
      checks++; if (in_ready !== (mq.size() < 2)) begin
        failures++; $display("FAIL rand_in_ready cyc%0d got %0b exp %0b", c, in_ready, mq.size() < 2);
      end
      tick();
      checks++; if (out_valid !== (mq.size() > 0)) begin
        failures++; $display("FAIL rand_out_valid cyc%0d got %0b exp %0b", c, out_valid, mq.size() > 0);
      end else if (mq.size() > 0 && (op_a !== mq[0].a || op_b !== mq[0].b || out_alu_op !== mq[0].op || out_rd_addr !== mq[0].rd)) begin
        failures++;
        $display("FAIL rand_entry cyc%0d got a=%h b=%h op=%h rd=%0d exp a=%h b=%h op=%h rd=%0d", c,
                 op_a, op_b, out_alu_op, out_rd_addr, mq[0].a, mq[0].b, mq[0].op, mq[0].rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_fwd_capture();
    test_fwd_hold();
    test_flush();
    test_shamt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
